// File: rtl/touch_pkg.sv
// touch_pkg -- shared types and constants for the touchscreen sample filter.
//   touch_state_t  : filter state (idle, debouncing, accumulating)
//   COORD_W        : width of one raw/averaged coordinate
//   DEF_*          : default parameter values for touch_filter
package touch_pkg;

    localparam int COORD_W = 12;

    localparam int                 DEF_AVG_LOG2   = 2;
    localparam logic [COORD_W-1:0] DEF_PEN_THRESH = 12'd100;
    localparam int                 DEF_DEBOUNCE   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEB   = 2'd1,
        ST_ACCUM = 2'd2
    } touch_state_t;

endpackage

// File: rtl/touch_avg_accum.sv
// touch_avg_accum -- one-axis running sum for the touch averager.
// Ports:
//   sclk, reset : clock, asynchronous active-high reset
//   clear       : zero the running sum (wins over add)
//   add         : add din into the running sum
//   din         : 12-bit sample
//   avg         : (sum + din) >> AVG_LOG2, i.e. the average that results if
//                 the current din is the last sample of a block
module touch_avg_accum
    import touch_pkg::*;
#(
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic               sclk,
    input  logic               reset,
    input  logic               clear,
    input  logic               add,
    input  logic [COORD_W-1:0] din,
    output logic [COORD_W-1:0] avg
);

    // 2^AVG_LOG2 * 4095 always fits in COORD_W + AVG_LOG2 bits.
    localparam int SUM_W = COORD_W + AVG_LOG2;

    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] sum_next;

    assign sum_next = sum_reg + SUM_W'(din);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (add) begin
            sum_reg <= sum_next;
        end
    end

    // Includes the in-flight sample so the block result is ready on the
    // same edge that consumes the final sample.
    assign avg = COORD_W'(sum_next >> AVG_LOG2);

endmodule

// File: rtl/touch_filter.sv
// touch_filter -- debounces pen contact and block-averages touch coordinates.
// Optional feature macro: TOUCH_FILTER_IRQ_EN (sticky pen-event interrupt).
// Without it irq is tied low and irq_clr is ignored.
// Ports:
//   sclk, reset        : clock, asynchronous active-high reset
//   x_in, y_in         : raw 12-bit coordinate pair
//   sample_valid       : one-cycle strobe qualifying x_in/y_in
//   irq_clr            : one-cycle strobe clearing irq
//   x_out, y_out       : averaged coordinates, held until next out_valid
//   out_valid          : one-cycle strobe for a new x_out/y_out
//   pen_down           : touch confirmed
//   irq                : sticky pen-down / pen-up interrupt
module touch_filter
    import touch_pkg::*;
#(
    parameter int                 AVG_LOG2   = DEF_AVG_LOG2,
    parameter logic [COORD_W-1:0] PEN_THRESH = DEF_PEN_THRESH,
    parameter int                 DEBOUNCE   = DEF_DEBOUNCE
) (
    input  logic               sclk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic               sample_valid,
    input  logic               irq_clr,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               out_valid,
    output logic               pen_down,
    output logic               irq
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [4:0] CNT_LAST = 5'((1 << AVG_LOG2) - 1);
    localparam bit         DEB_ONE  = (DEBOUNCE == 1);

    touch_state_t       state_reg;
    logic [3:0]         deb_cnt_reg;
    logic [4:0]         cnt_reg;
    logic [COORD_W-1:0] x_out_reg;
    logic [COORD_W-1:0] y_out_reg;
    logic               out_valid_reg;
    logic               pen_down_reg;

    logic               in_range;
    logic               out_range;
    logic               acc_add;
    logic               acc_last;
    logic               acc_clear;
    logic [COORD_W-1:0] x_avg;
    logic [COORD_W-1:0] y_avg;

    assign in_range  = sample_valid && (x_in >= PEN_THRESH) && (y_in >= PEN_THRESH);
    assign out_range = sample_valid && !in_range;

    // Accumulators stay cleared outside ACCUM so debounce samples never
    // contribute, and an aborted block leaves nothing behind.
    assign acc_add   = (state_reg == ST_ACCUM) && in_range;
    assign acc_last  = (cnt_reg == CNT_LAST);
    assign acc_clear = (state_reg != ST_ACCUM) || out_range || (acc_add && acc_last);

    touch_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_accum_x (
        .sclk  (sclk),
        .reset (reset),
        .clear (acc_clear),
        .add   (acc_add),
        .din   (x_in),
        .avg   (x_avg)
    );

    touch_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_accum_y (
        .sclk  (sclk),
        .reset (reset),
        .clear (acc_clear),
        .add   (acc_add),
        .din   (y_in),
        .avg   (y_avg)
    );

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            deb_cnt_reg   <= '0;
            cnt_reg       <= '0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
            out_valid_reg <= 1'b0;
            pen_down_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_range) begin
                        if (DEB_ONE) begin
                            state_reg    <= ST_ACCUM;
                            pen_down_reg <= 1'b1;
                            cnt_reg      <= '0;
                        end else begin
                            state_reg   <= ST_DEB;
                            deb_cnt_reg <= 4'd1;
                        end
                    end
                end
                ST_DEB: begin
                    if (in_range) begin
                        if (deb_cnt_reg == DEB_LAST) begin
                            state_reg    <= ST_ACCUM;
                            pen_down_reg <= 1'b1;
                            deb_cnt_reg  <= '0;
                            cnt_reg      <= '0;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + 4'd1;
                        end
                    end else if (out_range) begin
                        state_reg   <= ST_IDLE;
                        deb_cnt_reg <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (in_range) begin
                        if (acc_last) begin
                            x_out_reg     <= x_avg;
                            y_out_reg     <= y_avg;
                            out_valid_reg <= 1'b1;
                            cnt_reg       <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end else if (out_range) begin
                        state_reg    <= ST_IDLE;
                        pen_down_reg <= 1'b0;
                        cnt_reg      <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_out     = x_out_reg;
    assign y_out     = y_out_reg;
    assign out_valid = out_valid_reg;
    assign pen_down  = pen_down_reg;

`ifdef TOUCH_FILTER_IRQ_EN
    logic irq_reg;
    logic irq_set;

    // Pen-down (debounce complete) or pen-up (contact lost while accumulating).
    always_comb begin
        irq_set = 1'b0;
        if (in_range && (((state_reg == ST_DEB) && (deb_cnt_reg == DEB_LAST)) ||
                         ((state_reg == ST_IDLE) && DEB_ONE))) begin
            irq_set = 1'b1;
        end
        if ((state_reg == ST_ACCUM) && out_range) begin
            irq_set = 1'b1;
        end
    end

    // A new event wins over a coincident clear.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else if (irq_set) begin
            irq_reg <= 1'b1;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq = irq_reg;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: doc/touch_filter.md
TOUCH_FILTER -- requirements
Module: touch_filter

Interface
REQ-001 SHALL have parameter AVG_LOG2, 2, log2 of samples averaged per output (range 0..4).
REQ-002 SHALL have parameter PEN_THRESH, 12'd100, minimum raw value on both axes counted as a touch.
REQ-003 SHALL have parameter DEBOUNCE, 3, consecutive in-range samples required before pen-down (range 1..15).
REQ-004 SHALL have port sclk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port x_in  input  12  raw X sample from the touchscreen scan stage.
REQ-007 SHALL have port y_in  input  12  raw Y sample from the touchscreen scan stage.
REQ-008 SHALL have port sample_valid  input  1  one-cycle pulse; x_in/y_in form a complete pair.
REQ-009 SHALL have port irq_clr  input  1  one-cycle pulse clearing irq.
REQ-010 SHALL have port x_out  output  12  averaged X coordinate.
REQ-011 SHALL have port y_out  output  12  averaged Y coordinate.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse; new x_out/y_out.
REQ-013 SHALL have port pen_down  output  1  level; touch currently confirmed.
REQ-014 SHALL have port irq  output  1  sticky pen-event interrupt.

Function
REQ-015 SHALL treat a sample as in-range when sample_valid=1, x_in>=PEN_THRESH and y_in>=PEN_THRESH; out-of-range otherwise (sample_valid=1).
REQ-016 SHALL ignore x_in/y_in in every cycle with sample_valid=0; no state change.
REQ-017 SHALL implement states IDLE, DEB, ACCUM.
REQ-018 IDLE: pen_down=0; in-range sample -> DEB, deb_cnt=1 (or ->ACCUM directly when DEBOUNCE=1); out-of-range -> stay.
REQ-019 DEB: in-range sample increments deb_cnt; reaching DEBOUNCE -> ACCUM with accumulators and sample count cleared; out-of-range -> IDLE, deb_cnt=0.
REQ-020 Debounce samples SHALL NOT enter the accumulators.
REQ-021 ACCUM: pen_down=1; each in-range sample adds x_in/y_in into (12+AVG_LOG2)-bit sums, count+1.
REQ-022 On the 2^AVG_LOG2-th sample: x_out=sum_x>>AVG_LOG2, y_out=sum_y>>AVG_LOG2 (truncate), out_valid=1 for exactly the following cycle, sums/count cleared, remain ACCUM.
REQ-023 ACCUM out-of-range sample: -> IDLE, pen_down=0 next cycle, partial sums discarded, no out_valid, x_out/y_out hold.
REQ-024 x_out/y_out SHALL hold their last value until the next out_valid.
REQ-025 irq SHALL set on DEB->ACCUM (pen-down) and ACCUM->IDLE (pen-up), hold until irq_clr; set and irq_clr same cycle -> irq stays 1.
REQ-026 Sums SHALL never overflow: max 2^AVG_LOG2 * 4095 fits in 12+AVG_LOG2 bits.

Reset
REQ-027 Reset SHALL force IDLE, deb_cnt=0, count=0, sums=0, x_out=0, y_out=0, out_valid=0, pen_down=0, irq=0, immediately and independent of sclk.
REQ-028 Reset mid-accumulation SHALL discard partial data; first post-reset touch restarts full debounce.

Configuration
REQ-029 With TOUCH_FILTER_IRQ_EN defined, irq SHALL behave per REQ-025.
REQ-030 Without TOUCH_FILTER_IRQ_EN, irq SHALL be constant 0, irq_clr ignored, no irq flop synthesised; all other behaviour identical.

Structure
REQ-031 Package touch_pkg SHALL hold the state enum, COORD_W=12, default PEN_THRESH/DEBOUNCE/AVG_LOG2 constants.
REQ-032 One sub-module touch_avg_accum (clear, add, 12-bit in, shifted 12-bit out) SHALL be instanced once per axis.

Verification
REQ-033 Defaults; 3 in-range samples (x=0x400,y=0x300) -> pen_down=1 after 3rd, irq=1; 4 more (0x400,0x300),(0x404,0x304),(0x408,0x308),(0x40C,0x30C) -> out_valid one cycle, x_out=0x406, y_out=0x306.
REQ-034 Defaults; 2 in-range then x_in=50 -> stays pen_down=0, irq=0, back to IDLE; 3 further in-range needed for pen-down.
REQ-035 In ACCUM after 2 of 4 samples, y_in=0 -> pen_down=0 next cycle, irq=1, no out_valid, x_out/y_out unchanged.
REQ-036 irq=1, irq_clr coincident with pen-up event -> irq remains 1; lone irq_clr later -> irq=0.
REQ-037 Reset asserted mid-ACCUM between sclk edges -> all outputs 0 immediately; all-0xFFF samples with AVG_LOG2=4 -> x_out=y_out=0xFFF, no overflow.
REQ-038 Build without TOUCH_FILTER_IRQ_EN, rerun REQ-033 -> irq stays 0, data results identical.
